// File: rtl/carry_save_resolver_if.sv
// Handshake bundle for the carry-save resolver:
// operand pair in, resolved word plus flags out.
interface carry_save_resolver_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] s_vec;
  logic [N-1:0] c_vec;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output in_valid,
    output s_vec,
    output c_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  carry_out,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  s_vec,
    input  c_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output carry_out,
    output overflow
  );
endinterface

// File: rtl/carry_save_resolver.sv
// Resolves a carry-save pair into one binary word,
// CHUNK bits per cycle, with carry-out and signed overflow.
module carry_save_resolver #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  carry_save_resolver_if.slave bus,
  output logic                 busy
);
  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]             idx;
  logic                      cy;
  logic [NCH-1:0][CHUNK-1:0] s_q;
  logic [NCH-1:0][CHUNK-1:0] c_q;
  logic [NCH-1:0][CHUNK-1:0] r_q;
  logic                      co_q;
  logic                      ov_q;
  logic [CHUNK:0]            sum;
  logic                      last;
  logic                      accept;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (idx == IW'(NCH - 1));
  assign sum    = {1'b0, s_q[idx]}
                + {1'b0, c_q[idx]}
                + {{CHUNK{1'b0}}, cy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = BUSY;
      BUSY:    if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE:    bus.in_ready  = 1'b1;
      BUSY:    busy          = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Index does not advance past the last slice so it stays in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cy   <= 1'b0;
      s_q  <= '0;
      c_q  <= '0;
      r_q  <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      cy  <= 1'b0;
      s_q <= bus.s_vec;
      c_q <= bus.c_vec;
    end else if (state == BUSY) begin
      r_q[idx] <= sum[CHUNK-1:0];
      cy       <= sum[CHUNK];
      if (last) begin
        co_q <= sum[CHUNK];
        ov_q <= (s_q[NCH-1][CHUNK-1] == c_q[NCH-1][CHUNK-1])
              & (sum[CHUNK-1] != s_q[NCH-1][CHUNK-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.result    = r_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed and back-to-back random checks of the
// carry-save resolver against a scoreboard queue.
module tb_carry_save_resolver;
  localparam int N     = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = N / CHUNK;

  typedef struct packed {
    logic [N-1:0] r;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  carry_save_resolver_if #(.N(N)) bus ();

  carry_save_resolver #(.N(N), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  exp_t sb[$];
  int   vec  = 0;
  int   errs = 0;

  function automatic exp_t model(logic [N-1:0] s, logic [N-1:0] c);
    exp_t         e;
    logic [N:0]   w;
    w    = {1'b0, s} + {1'b0, c};
    e.r  = w[N-1:0];
    e.co = w[N];
    e.ov = (s[N-1] == c[N-1]) && (w[N-1] != s[N-1]);
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair; accepted on the first edge seen with in_ready high.
  task automatic push_in(logic [N-1:0] s, logic [N-1:0] c,
                         bit hold, bit track);
    int n = 0;
    bus.s_vec    = s;
    bus.c_vec    = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("accept_timeout", 64'd1, 64'd0);
    tick();
    if (!hold) bus.in_valid = 1'b0;
    if (track) sb.push_back(model(s, c));
  endtask

  task automatic pop_out(string tag);
    int   n = 0;
    exp_t e;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      chk({tag, "_timeout"}, 64'd1, 64'd0);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, {32'd0, bus.result}, {32'd0, e.r});
      chk({tag, "_co"}, {63'd0, bus.carry_out}, {63'd0, e.co});
      chk({tag, "_ov"}, {63'd0, bus.overflow}, {63'd0, e.ov});
    end
  endtask

  initial begin
    logic [N-1:0] held;
    bit           seen;
    time          t_prev;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s_vec     = '0;
    bus.c_vec     = '0;
    rst           = 1'b1;
    repeat (2) tick();
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    chk("rst_co", {63'd0, bus.carry_out}, 64'd0);
    chk("rst_ov", {63'd0, bus.overflow}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // 1: latency and simple carry across a chunk boundary
    push_in(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= NCH; k++) begin
      if (k > 1) tick();
      if (k < NCH) chk("t1_lat_low", {63'd0, bus.out_valid}, 64'd0);
    end
    tick();
    chk("t1_lat_high", {63'd0, bus.out_valid}, 64'd1);
    chk("t1_res_const", {32'd0, bus.result}, 64'h100);
    bus.out_ready = 1'b1;
    pop_out("t1");
    tick();
    bus.out_ready = 1'b0;
    chk("t1_idle_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("t1_idle_hold", {32'd0, bus.result}, 64'h100);

    // 2,3: full ripple and signed overflow corners
    bus.out_ready = 1'b1;
    push_in(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    pop_out("t2");
    chk("t2_co_const", {63'd0, bus.carry_out}, 64'd1);
    tick();
    push_in(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    pop_out("t3a");
    chk("t3a_ov_const", {63'd0, bus.overflow}, 64'd1);
    tick();
    push_in(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    pop_out("t3b");
    chk("t3b_co_const", {63'd0, bus.carry_out}, 64'd1);
    tick();

    // 4: consumer stalls in DONE while producer offers new data
    bus.out_ready = 1'b0;
    push_in(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    repeat (NCH) tick();
    held = bus.result;
    chk("t4_res_const", {32'd0, held}, 64'h2345_6789);
    bus.s_vec    = 32'hDEAD_BEEF;
    bus.c_vec    = 32'h0BAD_F00D;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("t4_stable", {32'd0, bus.result}, {32'd0, held});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    pop_out("t4");
    tick();
    bus.out_ready = 1'b0;
    chk("t4_no_accept", {63'd0, busy}, 64'd0);
    chk("t4_back_idle", {63'd0, bus.in_ready}, 64'd1);

    // 5: reset during the second BUSY cycle drops the operation
    push_in(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_res", {32'd0, bus.result}, 64'd0);
    chk("t5_co", {63'd0, bus.carry_out}, 64'd0);
    chk("t5_ov", {63'd0, bus.overflow}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2 * NCH + 2; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("t5_no_pulse", {63'd0, seen}, 64'd0);
    push_in(32'd3, 32'd4, 1'b0, 1'b1);
    pop_out("t5");
    chk("t5_res_const", {32'd0, bus.result}, 64'd7);
    tick();

    // 6: continuous traffic, one op per NCH+2 cycles
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          push_in($urandom, $urandom, 1'b1, 1'b1);
        end
        bus.in_valid = 1'b0;
      end
      begin
        t_prev = 0;
        for (int i = 0; i < 100; i++) begin
          pop_out("t6");
          if (i > 0)
            chk("t6_period", 64'($time - t_prev), 64'((NCH + 2) * 10));
          t_prev = $time;
          tick();
        end
      end
    join
    chk("t6_sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
